tree_walk_ctrl: RTL

Sequencer for one decision-tree node ROM: latches a 16-feature IEEE-754 vector, walks the tree from the root by issuing addresses to the synchronous tree ROM, compares the selected feature against each node threshold, and returns the leaf class. It sits between the feature-extraction front end and the vote/ensemble stage. One instance drives one tree ROM.

---
 rtl/tree_walk_ctrl.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/tree_walk_ctrl.sv
// Decision-tree walker: latches a float32 feature vector, walks one tree ROM from the root, returns the leaf class.
// Optional node-visit limit enabled by defining TREE_WALK_DEPTH_GUARD_EN.
module tree_walk_ctrl #(
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    NODE_WIDTH = 120,
  parameter logic [ADDR_WIDTH-1:0] ROOT_ADDR  = '0,
  parameter logic [3:0]            LEAF_CODE  = 4'h3,
  parameter int                    MAX_DEPTH  = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [511:0]          feature_vec,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [NODE_WIDTH-1:0] node_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            out_class,
  output logic                  out_err,
  output logic                  busy
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_EVAL, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            class_q, class_d;
  logic                  err_q, err_d;
  logic                  rdy_q;
  logic [511:0]          feat_q;

  function automatic logic is_nan(input logic [31:0] x);
    return (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
  endfunction

  // Monotonic unsigned key for IEEE-754 ordering; -0 folds onto +0 first.
  function automatic logic [31:0] order_key(input logic [31:0] x);
    logic [31:0] z;
    z = (x == 32'h8000_0000) ? 32'd0 : x;
    return z[31] ? ~z : {1'b1, z[30:0]};
  endfunction

  function automatic logic f_le_t(input logic [31:0] f, input logic [31:0] t);
    return !is_nan(f) && !is_nan(t) && (order_key(f) <= order_key(t));
  endfunction

  logic [3:0]  n_feat;
  logic [31:0] n_thr;
  logic [11:0] n_left, n_right, child;
  logic [3:0]  n_class;
  logic [31:0] f_sel;
  logic        is_leaf, go_left, child_bad, accept, depth_hit;
  logic        unused_node_bits;

  assign n_feat    = node_data[95:92];
  assign n_thr     = node_data[91:60];
  assign n_left    = node_data[27:16];
  assign n_right   = node_data[15:4];
  assign n_class   = node_data[3:0];
  assign is_leaf   = (n_feat == LEAF_CODE);
  assign f_sel     = feat_q[{n_feat, 5'b0} +: 32];
  assign go_left   = f_le_t(f_sel, n_thr);
  assign child     = go_left ? n_left : n_right;
  assign child_bad = (child >> ADDR_WIDTH) != 12'd0;
  assign accept    = in_valid && rdy_q;
  assign unused_node_bits = ^{node_data[NODE_WIDTH-1:96], node_data[59:28]};

`ifdef TREE_WALK_DEPTH_GUARD_EN
  localparam int DW = (MAX_DEPTH < 2) ? 1 : $clog2(MAX_DEPTH + 1);
  logic [DW-1:0] visits_q;

  assign depth_hit = (visits_q == DW'(MAX_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                             visits_q <= '0;
    else if (accept)                        visits_q <= '0;
    else if (state_q == S_EVAL && !is_leaf) visits_q <= visits_q + 1'b1;
  end
`else
  logic [31:0] unused_max_depth;
  assign unused_max_depth = 32'(MAX_DEPTH);
  assign depth_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    class_d = class_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_FETCH;
          addr_d  = ROOT_ADDR;
          class_d = 4'd0;
          err_d   = 1'b0;
        end
      end
      S_FETCH: state_d = S_EVAL;
      S_EVAL: begin
        if (is_leaf) begin
          class_d = n_class;
          state_d = S_DONE;
        end else if (depth_hit || child_bad) begin
          class_d = 4'd0;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          addr_d  = ADDR_WIDTH'(child);
          state_d = S_FETCH;
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      class_q <= 4'd0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      class_q <= class_d;
      err_q   <= err_d;
      rdy_q   <= (state_d == S_IDLE);
    end
  end

  // Feature vector is pure data: captured on accept, never reset.
  always_ff @(posedge clk) begin
    if (accept) feat_q <= feature_vec;
  end

  assign in_ready  = rdy_q;
  assign rom_addr  = addr_q;
  assign out_valid = (state_q == S_DONE);
  assign out_class = class_q;
  assign out_err   = err_q;
  assign busy      = (state_q != S_IDLE);

endmodule
